// File: rtl/chain_constraint_sequencer_pkg.sv
// Shared definitions for the particle-chain constraint sequencer:
// Q16.16 position width and the sequencer FSM encoding.
package chain_constraint_sequencer_pkg;

  localparam int Q_W   = 32;
  localparam int POS_W = 2 * Q_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/chain_pos_store.sv
// Particle position register file: one synchronous write port, three
// combinational triplet read ports and one combinational host read port.
module chain_pos_store
  import chain_constraint_sequencer_pkg::*;
#(
  parameter int N_PART = 16,
  parameter int AW     = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [Q_W-1:0] wx,
  input  logic [Q_W-1:0] wy,
  input  logic [AW-1:0]  up_addr,
  input  logic [AW-1:0]  self_addr,
  input  logic [AW-1:0]  dn_addr,
  input  logic [AW-1:0]  host_addr,
  output logic [Q_W-1:0] up_x,
  output logic [Q_W-1:0] up_y,
  output logic [Q_W-1:0] self_x,
  output logic [Q_W-1:0] self_y,
  output logic [Q_W-1:0] dn_x,
  output logic [Q_W-1:0] dn_y,
  output logic [Q_W-1:0] host_x,
  output logic [Q_W-1:0] host_y
);

  // Each entry packs {x, y}.
  logic [POS_W-1:0] mem_q [N_PART];
  logic [POS_W-1:0] mem_d [N_PART];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = {wx, wy};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PART; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign {up_x, up_y}     = mem_q[up_addr];
  assign {self_x, self_y} = mem_q[self_addr];
  assign {dn_x, dn_y}     = mem_q[dn_addr];
  assign {host_x, host_y} = mem_q[host_addr];

endmodule

// File: rtl/chain_constraint_sequencer.sv
// Sweeps a particle chain through the EnforceConstraint datapath in
// Gauss-Seidel order, ITERS sweeps per start, writing results back in place.
module chain_constraint_sequencer
  import chain_constraint_sequencer_pkg::*;
#(
  parameter int          N_PART   = 16,
  parameter int          AW       = 4,
  parameter int          ITERS    = 4,
  parameter logic [15:0] PIN_MASK = 16'h0001
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_x,
  input  logic [31:0]   wr_y,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_x,
  output logic [31:0]   rd_y,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ec_req,
  output logic [31:0]   ec_up_x,
  output logic [31:0]   ec_up_y,
  output logic [31:0]   ec_x,
  output logic [31:0]   ec_y,
  output logic [31:0]   ec_dn_x,
  output logic [31:0]   ec_dn_y,
  output logic          ec_pinned,
  input  logic          ec_ack,
  input  logic [31:0]   ec_res_x,
  input  logic [31:0]   ec_res_y
);

  localparam int             IW        = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [AW-1:0]  LAST_IDX  = AW'(N_PART - 1);
  localparam logic [IW-1:0]  LAST_ITER = IW'(ITERS - 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ec_req_q, ec_req_d;
  logic [Q_W-1:0] res_x_q, res_x_d;
  logic [Q_W-1:0] res_y_q, res_y_d;

  logic           st_we;
  logic [AW-1:0]  st_waddr;
  logic [Q_W-1:0] st_wx, st_wy;
  logic [AW-1:0]  up_addr, dn_addr;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    iter_d   = iter_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ec_req_d = ec_req_q;
    res_x_d  = res_x_q;
    res_y_d  = res_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ISSUE;
          idx_d    = '0;
          iter_d   = '0;
          busy_d   = 1'b1;
          ec_req_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (ec_req_q && ec_ack) begin
          res_x_d  = ec_res_x;
          res_y_d  = ec_res_y;
          ec_req_d = 1'b0;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          iter_d = iter_q + IW'(1);
          if (iter_q == LAST_ITER) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            ec_req_d = 1'b1;
          end
        end else begin
          idx_d    = idx_q + AW'(1);
          state_d  = ST_ISSUE;
          ec_req_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        ec_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ec_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      iter_q   <= iter_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ec_req_q <= ec_req_d;
    end
  end

  // Result latch is pure data; it is always written before being consumed.
  always_ff @(posedge clk) begin
    res_x_q <= res_x_d;
    res_y_q <= res_y_d;
  end

  // Write-back owns the port during WB; host writes only land while idle.
  always_comb begin
    st_we    = 1'b0;
    st_waddr = wr_addr;
    st_wx    = wr_x;
    st_wy    = wr_y;
    if (state_q == ST_WB) begin
      st_we    = 1'b1;
      st_waddr = idx_q;
      st_wx    = res_x_q;
      st_wy    = res_y_q;
    end else if (wr_en && !busy_q) begin
      st_we = 1'b1;
    end
  end

  // Chain ends reuse self as the missing neighbour.
  assign up_addr = (idx_q == '0)      ? idx_q : idx_q - AW'(1);
  assign dn_addr = (idx_q == LAST_IDX) ? idx_q : idx_q + AW'(1);

  chain_pos_store #(
    .N_PART (N_PART),
    .AW     (AW)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .we        (st_we),
    .waddr     (st_waddr),
    .wx        (st_wx),
    .wy        (st_wy),
    .up_addr   (up_addr),
    .self_addr (idx_q),
    .dn_addr   (dn_addr),
    .host_addr (rd_addr),
    .up_x      (ec_up_x),
    .up_y      (ec_up_y),
    .self_x    (ec_x),
    .self_y    (ec_y),
    .dn_x      (ec_dn_x),
    .dn_y      (ec_dn_y),
    .host_x    (rd_x),
    .host_y    (rd_y)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign ec_req    = ec_req_q;
  assign ec_pinned = PIN_MASK[idx_q];

endmodule
